// File: rtl/transformer_pkg.sv
// Shared constants for the transformer datapath: vector size, weight-store
// select IDs, fixed-point formats and the state encodings of the norm stage.
package transformer_pkg;

    localparam int DIM = 128;

    localparam logic [5:0] SEL_TOK_EMB   = 6'd0;
    localparam logic [5:0] SEL_POS_EMB   = 6'd1;
    localparam logic [5:0] SEL_LN1_GAMMA = 6'd2;

    localparam int GAMMA_FRAC = 6;
    localparam int ACT_FRAC   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUMSQ,
        ST_RECIP,
        ST_SCALE
    } rms_state_e;

    typedef enum logic [1:0] {
        RC_IDLE,
        RC_SQRT,
        RC_DIV
    } recip_state_e;

endpackage

// File: rtl/rms_recip.sv
// Reciprocal RMS: r = floor(sqrt((acc>>7)+EPS)) by restoring digit recurrence,
// then inv = floor(32768/r) by restoring division, one bit per cycle each.
module rms_recip
    import transformer_pkg::*;
#(
    parameter int EPS = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [21:0] acc_i,
    output logic [15:0] inv_o,
    output logic        done_o
);

    recip_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  rad_q, rad_d;
    logic [9:0]   rem_q, rem_d;
    logic [7:0]   root_q, root_d;
    logic [15:0]  quo_q, quo_d;

    logic [11:0] rem_sh, trial;
    logic [8:0]  drem_sh, dvsr;

    assign rem_sh  = {rem_q, rad_q[15:14]};
    assign trial   = {2'd0, root_q, 2'b01};
    // Dividend 32768 has only bit 15 set, which is consumed on the first step.
    assign drem_sh = {rem_q[7:0], (cnt_q == 4'd0)};
    assign dvsr    = {1'b0, root_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        quo_d   = quo_q;
        case (state_q)
            RC_IDLE: begin
                if (start_i) begin
                    rad_d   = 16'(acc_i >> 7) + 16'(EPS);
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = RC_SQRT;
                end
            end
            RC_SQRT: begin
                rad_d = {rad_q[13:0], 2'b00};
                if (rem_sh >= trial) begin
                    rem_d  = 10'(rem_sh - trial);
                    root_d = {root_q[6:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[9:0];
                    root_d = {root_q[6:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = RC_DIV;
                end
            end
            RC_DIV: begin
                if (drem_sh >= dvsr) begin
                    rem_d = {1'b0, drem_sh - dvsr};
                    quo_d = {quo_q[14:0], 1'b1};
                end else begin
                    rem_d = {1'b0, drem_sh};
                    quo_d = {quo_q[14:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = RC_IDLE;
            end
            default: state_d = RC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RC_IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            quo_q   <= quo_d;
        end
    end

    // done_o marks the last divide step; inv_o holds the result from the next cycle on.
    assign done_o = (state_q == RC_DIV) && (cnt_q == 4'd15);
    assign inv_o  = quo_q;

endmodule

// File: rtl/rmsnorm.sv
// Per-token RMS normalisation: sum of squares while gamma streams in, then a
// serial reciprocal RMS, then one element scaled and saturated per cycle.
module rmsnorm
    import transformer_pkg::*;
#(
    parameter int          DIM        = transformer_pkg::DIM,
    parameter logic [5:0]  GAMMA_SEL  = SEL_LN1_GAMMA,
    parameter logic [15:0] GAMMA_BASE = 16'd0,
    parameter int          EPS        = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [DIM*8-1:0] x_i,
    output logic [5:0]       w_sel_o,
    output logic [15:0]      w_addr_o,
    input  logic [7:0]       w_data_i,
    output logic [DIM*8-1:0] out_o,
    output logic             done_o,
    output logic             busy_o
);

    // inv carries 2^15/r; this shift lands x*gamma*inv in Q2.5.
    localparam int SHIFT = 15 + GAMMA_FRAC - ACT_FRAC;

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)  return 8'sh7f;
        if (v < -32'sd128) return 8'sh80;
        return v[7:0];
    endfunction

    rms_state_e       state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [DIM*8-1:0] x_buf_q, x_buf_d;
    logic [DIM*8-1:0] gamma_q, gamma_d;
    logic [21:0]      acc_q, acc_d;
    logic [DIM*8-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [5:0]       w_sel_q, w_sel_d;
    logic [15:0]      w_addr_q, w_addr_d;

    logic               recip_start, recip_done;
    logic [15:0]        recip_inv;
    logic [6:0]         rd_idx;
    logic signed [7:0]  x_el, g_el;
    logic signed [15:0] x_sq, xg;
    logic signed [31:0] prod, y;

    // SUMSQ consumes element idx-1 because gamma arrives one cycle after its address.
    assign rd_idx = (state_q == ST_SUMSQ) ? 7'(idx_q - 8'd1) : idx_q[6:0];
    assign x_el   = $signed(x_buf_q[{rd_idx, 3'b000} +: 8]);
    assign g_el   = $signed(gamma_q[{rd_idx, 3'b000} +: 8]);
    assign x_sq   = $signed({{8{x_el[7]}}, x_el}) * $signed({{8{x_el[7]}}, x_el});
    assign xg     = $signed({{8{x_el[7]}}, x_el}) * $signed({{8{g_el[7]}}, g_el});
    assign prod   = $signed({{16{xg[15]}}, xg}) * $signed({16'd0, recip_inv});
    assign y      = prod >>> SHIFT;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_buf_d     = x_buf_q;
        gamma_d     = gamma_q;
        acc_d       = acc_q;
        out_d       = out_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        w_sel_d     = w_sel_q;
        w_addr_d    = w_addr_q;
        recip_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    x_buf_d  = x_i;
                    idx_d    = '0;
                    acc_d    = '0;
                    busy_d   = 1'b1;
                    w_sel_d  = GAMMA_SEL;
                    w_addr_d = GAMMA_BASE;
                    state_d  = ST_SUMSQ;
                end
            end
            ST_SUMSQ: begin
                if (idx_q < 8'd127) w_addr_d = GAMMA_BASE + {8'd0, idx_q} + 16'd1;
                if (idx_q != 8'd0) begin
                    gamma_d[{rd_idx, 3'b000} +: 8] = w_data_i;
                    acc_d = acc_q + {6'd0, $unsigned(x_sq)};
                end
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'd128) begin
                    idx_d       = '0;
                    recip_start = 1'b1;
                    state_d     = ST_RECIP;
                end
            end
            ST_RECIP: begin
                if (recip_done) begin
                    idx_d   = '0;
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                out_d[{idx_q[6:0], 3'b000} +: 8] = sat8(y);
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'd127) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    w_sel_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            x_buf_q  <= '0;
            gamma_q  <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            w_sel_q  <= '0;
            w_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_buf_q  <= x_buf_d;
            gamma_q  <= gamma_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            w_sel_q  <= w_sel_d;
            w_addr_q <= w_addr_d;
        end
    end

    // The final square is added on the same edge the reciprocal unit starts.
    rms_recip #(
        .EPS(EPS)
    ) u_recip (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(recip_start),
        .acc_i  (acc_d),
        .inv_o  (recip_inv),
        .done_o (recip_done)
    );

    assign out_o    = out_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;
    assign w_sel_o  = w_sel_q;
    assign w_addr_o = w_addr_q;

endmodule

// File: doc/rmsnorm.md
Name: rmsnorm

Overview:
- Per-token RMS normalisation stage; sits directly downstream of the token+position embedding stage and upstream of the attention-block projections.
- Latches a 128 x int8 vector and computes the mean square. Forms 1/rms using a serial integer sqrt and a serial divider.
- Multiplies each element by its int8 gamma, read from the weight store. Emits a 128 x int8 normalised vector in Q2.5.

Parameters:
- DIM, 128, vector length; RTL supports only 128.
- GAMMA_SEL, 6'd2, weight_store select for the gamma table.
- GAMMA_BASE, 16'd0, first gamma address inside GAMMA_SEL.
- EPS, 1, integer added to the mean square before sqrt; must be >= 1.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- x_i  in  DIM*8  input vector; element i at [i*8+:8], signed; sampled on the start edge only.
- w_sel_o  out  6  weight_store select.
- w_addr_o  out  16  weight_store byte address.
- w_data_i  in  8  weight_store read data, 1-cycle registered latency.
- out_o  out  DIM*8  normalised vector, same packing as x_i.
- done_o  out  1  one-cycle pulse; out_o complete.
- busy_o  out  1  high from the start edge until the edge that raises done_o.

Behaviour:
- Reset (rst_ni low, any time, including mid-operation):
  - Outputs: out_o=0, done_o=0, busy_o=0, w_sel_o=0, w_addr_o=0.
  - Internal state: state=IDLE; all counters, accumulators and buffers cleared.
  - No partial result survives reset.
- IDLE:
  - On start_i: latch x_i into x_buf, idx=0, busy_o=1, w_sel_o=GAMMA_SEL, w_addr_o=GAMMA_BASE; go to SUMSQ.
  - start_i in any other state is ignored.
- SUMSQ, 129 cycles, idx 0..128:
  - Address issue: for idx<127, w_addr_o=GAMMA_BASE+idx+1.
  - For idx>0: gamma_buf[idx-1]=w_data_i, and acc += x_buf[idx-1]^2.
  - acc: 22-bit unsigned, max 128*16384 = 2^21, no overflow.
  - At idx==128: go to SQRT.
- SQRT, 8 cycles:
  - ms = (acc>>7) + EPS, 16 bits, range 1..16385.
  - Restoring bit-serial floor square root, one result bit per cycle, gives r: 8-bit unsigned, 1..128.
- DIV, 16 cycles:
  - inv = floor(32768 / r), restoring divide, one quotient bit per cycle.
  - inv: 16-bit unsigned, 256..32768.
  - r is never 0 because EPS>=1.
- SCALE, 128 cycles, idx 0..127:
  - p = x_buf[idx] * gamma_buf[idx] * inv, computed as signed 32-bit.
  - y = p >>> 16, arithmetic shift (floor toward -inf).
  - Saturate y to [-128,127]; write out_o[idx*8+:8].
  - At idx==127: done_o=1, busy_o=0, w_sel_o=0, go to IDLE.
- Number formats: gamma is Q1.6 (64 = 1.0); output is Q2.5 (32 = 1.0 x rms).
- Latency: the start edge is edge 0. done_o goes high after edge 281, i.e. 129+8+16+128 states after start. It drops after edge 282.
- out_o elements change only during SCALE. Between runs, out_o holds the last result.
- start_i on the same edge done_o rises is not accepted, because the state is not yet IDLE. start_i on the following edge is accepted.
- x_i may change freely after the start edge.

Decomposition:
- Shared package (transformer_pkg) holds:
  - DIM.
  - Weight-store select IDs: SEL_TOK_EMB=0, SEL_POS_EMB=1, SEL_LN1_GAMMA=2.
  - Q-format constants: GAMMA_FRAC=6, ACT_FRAC=5.
  - State encoding localparams for this block.
- One natural sub-module: rms_recip. It takes the 22-bit acc and EPS and returns the 16-bit inv plus a done strobe. It holds the SQRT and DIV sequencing and can be unit-tested alone.
- Top level keeps the SUMSQ and SCALE loops and the weight-store port.

Test Plan:
- Nominal: x all 64, gamma all 64 -> acc=524288, r=64, inv=512, every out byte = 32; done_o after edge 281; busy_o high 281 cycles.
- Zero input: x all 0, gamma all 127 -> r=1, inv=32768, out all 0; no X.
- Positive saturation: x[0]=127, others 0, gamma all 127 -> r=11, inv=2978, out[0]=127, others 0.
- Negative saturation and floor: x[0]=-128, others 0, gamma all 127 -> out[0]=-128. Second run: x all -64, gamma all 64 -> out all -32.
- Handshake: start_i pulsed at cycles 5 and 100 of a run -> second pulse ignored, exactly one done_o. Check the w_addr_o sequence GAMMA_BASE..GAMMA_BASE+127 with w_sel_o=2.
- Reset mid-SCALE: assert rst_ni low at cycle 200 -> all outputs 0 immediately (async). After release, a fresh start gives the nominal result at the same latency.
